// File: rtl/ex_stage_unit.sv
// Execute stage: single-cycle ALU/address path, 16-step shift-add multiplier, EX/MEM output register.
// Latency 1 for ALU/LW/SW, 18 cycles for MUL/MULH; ex_stall holds ID/EX while a multiply is accepted or busy.
module ex_stage_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  opcode_ex,
  input  logic [3:0]  rd_ex,
  input  logic [15:0] rs1_data_ex,
  input  logic [15:0] rs2_data_ex,
  input  logic [15:0] imm_val_ex,
  output logic        ex_stall,
  output logic [15:0] mem_alu_result,
  output logic [15:0] mem_store_data,
  output logic [3:0]  mem_rd,
  output logic        mem_reg_wr,
  output logic        mem_mem_rd,
  output logic        mem_mem_wr
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_SLL  = 4'h6;
  localparam logic [3:0] OP_SRL  = 4'h7;
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_LW   = 4'h9;
  localparam logic [3:0] OP_SW   = 4'hA;
  localparam logic [3:0] OP_MUL  = 4'hB;
  localparam logic [3:0] OP_MULH = 4'hC;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] prod_q;
  logic [31:0] mcand_q;
  logic [15:0] mplier_q;
  logic [3:0]  mrd_q;
  logic        hi_q;

  logic [15:0] alu_q, sd_q;
  logic [3:0]  rd_q;
  logic        rw_q, mr_q, mw_q;

  logic [15:0] alu_d, sd_d;
  logic [3:0]  rd_d;
  logic        rw_d, mr_d, mw_d;

  logic        is_mul;
  logic [15:0] addr_sum;
  logic [31:0] prod_step;

  assign is_mul    = (opcode_ex == OP_MUL) || (opcode_ex == OP_MULH);
  assign addr_sum  = rs1_data_ex + imm_val_ex;
  assign prod_step = prod_q + (mplier_q[0] ? mcand_q : 32'd0);

  // Gated by rst_n so the stall drops the instant reset asserts, even with a MUL on the inputs.
  assign ex_stall = rst_n && (((state_q == IDLE) && is_mul) || (state_q == BUSY));

  always_comb begin
    alu_d = '0;
    sd_d  = '0;
    rd_d  = '0;
    rw_d  = 1'b0;
    mr_d  = 1'b0;
    mw_d  = 1'b0;
    if (state_q == DONE) begin
      alu_d = hi_q ? prod_q[31:16] : prod_q[15:0];
      rd_d  = mrd_q;
      rw_d  = 1'b1;
    end else if (state_q == IDLE && !is_mul) begin
      rd_d = rd_ex;
      rw_d = 1'b1;
      case (opcode_ex)
        OP_ADD:  alu_d = rs1_data_ex + rs2_data_ex;
        OP_SUB:  alu_d = rs1_data_ex - rs2_data_ex;
        OP_AND:  alu_d = rs1_data_ex & rs2_data_ex;
        OP_OR:   alu_d = rs1_data_ex | rs2_data_ex;
        OP_XOR:  alu_d = rs1_data_ex ^ rs2_data_ex;
        OP_SLL:  alu_d = rs1_data_ex << rs2_data_ex[3:0];
        OP_SRL:  alu_d = rs1_data_ex >> rs2_data_ex[3:0];
        OP_ADDI: alu_d = addr_sum;
        OP_LW: begin
          alu_d = addr_sum;
          mr_d  = 1'b1;
        end
        OP_SW: begin
          alu_d = addr_sum;
          sd_d  = rs2_data_ex;
          rw_d  = 1'b0;
          mw_d  = 1'b1;
        end
        default: begin
          rd_d = '0;
          rw_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      mrd_q    <= '0;
      hi_q     <= 1'b0;
      alu_q    <= '0;
      sd_q     <= '0;
      rd_q     <= '0;
      rw_q     <= 1'b0;
      mr_q     <= 1'b0;
      mw_q     <= 1'b0;
    end else begin
      alu_q <= alu_d;
      sd_q  <= sd_d;
      rd_q  <= rd_d;
      rw_q  <= rw_d;
      mr_q  <= mr_d;
      mw_q  <= mw_d;
      case (state_q)
        IDLE: begin
          if (is_mul) begin
            mcand_q  <= {16'd0, rs1_data_ex};
            mplier_q <= rs2_data_ex;
            mrd_q    <= rd_ex;
            hi_q     <= (opcode_ex == OP_MULH);
            prod_q   <= '0;
            cnt_q    <= '0;
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          prod_q   <= prod_step;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_alu_result = alu_q;
  assign mem_store_data = sd_q;
  assign mem_rd         = rd_q;
  assign mem_reg_wr     = rw_q;
  assign mem_mem_rd     = mr_q;
  assign mem_mem_wr     = mw_q;

endmodule

// File: doc/ex_stage_unit.md
# ex_stage_unit

Execute stage of the 16-bit pipelined core. Consumes the decoded instruction fields held in the ID/EX pipeline register and computes single-cycle ALU results and load/store addresses. It also computes a 16-cycle iterative unsigned multiply, and registers the outcome into the EX/MEM boundary. While a multiply is in progress it asserts `ex_stall`, so the ID/EX register and upstream stages hold.

## Interface
Parameters: none.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `opcode_ex` input 4: opcode from ID/EX.
- `rd_ex` input 4: destination register from ID/EX.
- `rs1_data_ex` input 16: source operand 1.
- `rs2_data_ex` input 16: source operand 2 / store data.
- `imm_val_ex` input 16: sign-extended immediate/offset.
- `ex_stall` output 1: combinational; ID/EX and earlier stages must hold while high.
- `mem_alu_result` output 16: registered ALU result or memory address.
- `mem_store_data` output 16: registered store data.
- `mem_rd` output 4: registered destination register.
- `mem_reg_wr` output 1: registered register-write enable.
- `mem_mem_rd` output 1: registered load enable.
- `mem_mem_wr` output 1: registered store enable.

## Operation
- Opcode map:
  - 0 NOP
  - 1 ADD: rs1+rs2
  - 2 SUB: rs1−rs2
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 SLL: rs1 << rs2[3:0]
  - 7 SRL: logical, rs1 >> rs2[3:0]
  - 8 ADDI: rs1+imm
  - 9 LW: addr = rs1+imm
  - A SW: addr = rs1+imm, data = rs2
  - B MUL: low 16 bits of the unsigned product
  - C MULH: high 16 bits of the unsigned product
  - D–F reserved, treated as NOP.
- Arithmetic is modulo 2^16. Carries and overflow are discarded; no flags are produced.
- Control outputs:
  - `reg_wr` = 1 for opcodes 1–9, B, C.
  - `mem_rd` = 1 only for LW.
  - `mem_wr` = 1 only for SW.
  - `mem_store_data` = rs2 for SW, 0 otherwise.
- NOP, reserved opcodes and bubbles produce all EX/MEM outputs 0.
- Multiplier FSM, states IDLE, BUSY, DONE:
  - IDLE: if the opcode is B or C, latch rs1 (multiplicand), rs2 (multiplier), rd and the high/low select. Clear the 32-bit product, set counter to 0, go to BUSY. Any other opcode passes through the single-cycle path.
  - BUSY: one shift-add step per cycle, examining one multiplier bit, LSB first. The counter increments each cycle; after the step with counter = 15, go to DONE.
  - DONE: present the selected product half with the latched rd and `reg_wr`=1 to the EX/MEM register. Ignore the inputs. Go to IDLE.
- Bubbles: in the IDLE-accept cycle and in every BUSY cycle, the EX/MEM register loads a bubble (all zero). MEM must never see a duplicated instruction.
- `ex_stall`:
  - High when (IDLE and opcode ∈ {B, C}) or BUSY.
  - Low in DONE and in all other IDLE cases.
  - Low while `rst_n` is low.

## Timing
- Reset (async, while `rst_n` = 0): FSM is IDLE, counter 0, product 0. All registered outputs are 0, and `ex_stall` is 0.
- Single-cycle ops: inputs present in cycle T produce the EX/MEM outputs after the rising edge ending T. Latency is 1; there is no stall.
- Multiply timeline:
  - Accept in cycle T, with `ex_stall` high.
  - BUSY in T+1..T+16, with `ex_stall` high throughout.
  - DONE in T+17, with `ex_stall` low.
  - The result appears on the EX/MEM outputs after the edge ending T+17, and ID/EX advances at that same edge.
  - Total: 17 stall cycles, 18 cycles of EX occupancy.
- Back-to-back multiplies: a MUL that follows directly in ID/EX is accepted in the cycle after DONE (IDLE again). It has the same 18-cycle profile; there is no overlap.
- Reset mid-multiply: the FSM aborts immediately to IDLE and `ex_stall` drops asynchronously. The partial product is discarded and no result is written.
- Operands are sampled only in the accept cycle. Changes on the inputs during BUSY/DONE have no effect.

## Test plan
- Reset check: assert `rst_n` = 0 with random inputs → all outputs 0 and `ex_stall` = 0. Then release with opcode 0 → outputs stay 0.
- ALU wrap and shifts:
  - ADD 0xFFFF+0x0002 → `mem_alu_result` 0x0001, `reg_wr` 1.
  - SUB 0x0000−0x0001 → 0xFFFF.
  - SLL 0x0001 by rs2 = 0x0013 → 0x0008.
  - SRL 0x8000 by 0x000F → 0x0001.
- Load/store:
  - LW rs1 = 0x0100, imm = 0xFFFE → addr 0x00FE, `mem_rd` 1, `reg_wr` 1.
  - SW rs1 = 0x0010, imm = 0x0004, rs2 = 0xBEEF → addr 0x0014, `mem_store_data` 0xBEEF, `mem_wr` 1, `reg_wr` 0.
- MUL timing:
  - MUL 0x1234×0x0010 with rd = 5 → `ex_stall` high exactly 17 cycles.
  - Outputs are bubbles (all zero) during the stall.
  - Then result 0x2340 with rd 5 and `reg_wr` 1, exactly one cycle.
- MULH: 0xFFFF×0xFFFF → 0xFFFE. The same operands with MUL → 0x0001. Back-to-back MUL then MULH → two separate 18-cycle sequences, results in order.
- Reset mid-multiply: pulse `rst_n` low at BUSY cycle 8 → `ex_stall` low immediately. No product is ever emitted; a following ADD 3+4 yields 0x0007 with latency 1.
